// File: rtl/pipeline_stage_buffer.sv
// Inter-stage pipeline buffer: DEPTH-entry in-order queue with valid/ready
// handshake on both sides, flush-to-bubble, and a saturating stall counter.
// All state changes on the falling edge of sys_clk, like every pipeline
// register in the core. in_ready depends only on registered occupancy, so
// there is no combinational path from out_ready back to in_ready.
module pipeline_stage_buffer #(
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                CNT_W  = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       in_flush,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       out_is_bubble,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;

  // Handshake qualifiers and explicitly wrapped pointer successors
  always_comb begin
    w_out_valid  = (r_count != '0);
    w_in_ready   = (r_count < DEPTH_C);
    w_push       = in_valid & w_in_ready & ~in_flush;
    w_pop        = w_out_valid & out_ready & ~in_flush;
    w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
    w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  end

  // Payload storage; left unreset because a stale entry is never visible
  always_ff @(negedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop
  always_ff @(negedge sys_clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (in_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Count downstream stall cycles, saturating at all-ones; only reset clears
  always_ff @(negedge sys_clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && !in_flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Outputs derive from registered state only
  always_comb begin
    in_ready      = w_in_ready;
    out_valid     = w_out_valid;
    out_is_bubble = ~w_out_valid;
    out_data      = w_out_valid ? r_mem[r_rd_ptr] : BUBBLE;
    occupancy     = r_count;
    stall_cnt     = r_stall_cnt;
  end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench for pipeline_stage_buffer. Three instances: DEPTH=2 with a
// non-zero bubble (streaming, fill/stall, flush), DEPTH=3 with a 4-bit stall
// counter (wrap-around, saturation, reset while full) and DEPTH=1.
// The DUT updates on the falling edge; the bench drives and samples on the
// rising edge.
module tb_pipeline_stage_buffer;

  logic sys_clk = 1'b1;
  logic rst_n;
  always #5 sys_clk = ~sys_clk;

  // instance A: DEPTH=2, BUBBLE=BEEF
  logic        a_in_valid, a_in_ready, a_in_flush, a_out_valid, a_out_ready, a_out_is_bubble;
  logic [15:0] a_in_data, a_out_data, a_stall_cnt;
  logic [1:0]  a_occupancy;
  // instance B: DEPTH=3, CNT_W=4
  logic        b_in_valid, b_in_ready, b_in_flush, b_out_valid, b_out_ready, b_out_is_bubble;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_stall_cnt;
  logic [1:0]  b_occupancy;
  // instance C: DEPTH=1
  logic        c_in_valid, c_in_ready, c_in_flush, c_out_valid, c_out_ready, c_out_is_bubble;
  logic [15:0] c_in_data, c_out_data;
  logic [7:0]  c_stall_cnt;
  logic [0:0]  c_occupancy;

  pipeline_stage_buffer #(.DATA_W(16), .DEPTH(2), .BUBBLE(16'hBEEF), .CNT_W(16)) u_a (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready), .in_flush(a_in_flush),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .out_is_bubble(a_out_is_bubble), .occupancy(a_occupancy), .stall_cnt(a_stall_cnt));

  pipeline_stage_buffer #(.DATA_W(16), .DEPTH(3), .BUBBLE(16'h0000), .CNT_W(4)) u_b (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready), .in_flush(b_in_flush),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .out_is_bubble(b_out_is_bubble), .occupancy(b_occupancy), .stall_cnt(b_stall_cnt));

  pipeline_stage_buffer #(.DATA_W(16), .DEPTH(1), .BUBBLE(16'h0000), .CNT_W(8)) u_c (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready), .in_flush(c_in_flush),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
    .out_is_bubble(c_out_is_bubble), .occupancy(c_occupancy), .stall_cnt(c_stall_cnt));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
  endtask

  initial begin
    int wr_idx;
    int rd_idx;

    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hDEAD; a_in_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'hDEAD; b_in_flush = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = 16'hDEAD; c_in_flush = 1'b0; c_out_ready = 1'b0;

    // reset held for two falling edges with a valid input presented
    tick(); tick();
    chk("rst_a_occ",    32'(a_occupancy), 32'd0);
    chk("rst_a_oval",   32'(a_out_valid), 32'd0);
    chk("rst_a_odata",  32'(a_out_data),  32'hBEEF);
    chk("rst_a_bubble", 32'(a_out_is_bubble), 32'd1);
    chk("rst_a_irdy",   32'(a_in_ready),  32'd1);
    chk("rst_a_stall",  32'(a_stall_cnt), 32'd0);
    chk("rst_b_occ",    32'(b_occupancy), 32'd0);
    chk("rst_c_irdy",   32'(c_in_ready),  32'd1);
    rst_n = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;

    // streaming on A
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 16'h0001;
    tick();
    chk("str_out1", 32'(a_out_data), 32'h1);
    chk("str_occ1", 32'(a_occupancy), 32'd1);
    a_in_data = 16'h0002;
    tick();
    chk("str_out2", 32'(a_out_data), 32'h2);
    chk("str_occ2", 32'(a_occupancy), 32'd1);
    a_in_data = 16'h0003;
    tick();
    chk("str_out3", 32'(a_out_data), 32'h3);
    chk("str_occ3", 32'(a_occupancy), 32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("str_empty", 32'(a_occupancy), 32'd0);
    chk("str_bubble", 32'(a_out_data), 32'hBEEF);
    chk("str_stall", 32'(a_stall_cnt), 32'd0);

    // fill / stall on A
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h000A;
    tick();
    chk("fill_irdy1",  32'(a_in_ready), 32'd1);
    chk("fill_stall1", 32'(a_stall_cnt), 32'd0);
    a_in_data = 16'h000B;
    tick();
    chk("fill_occ2",   32'(a_occupancy), 32'd2);
    chk("fill_irdy2",  32'(a_in_ready), 32'd0);
    chk("fill_stall2", 32'(a_stall_cnt), 32'd1);
    chk("fill_head",   32'(a_out_data), 32'hA);
    a_in_data = 16'h000C;
    tick();
    chk("fill_hold",   32'(a_occupancy), 32'd2);
    chk("fill_stall3", 32'(a_stall_cnt), 32'd2);
    chk("fill_head2",  32'(a_out_data), 32'hA);
    a_out_ready = 1'b1;
    tick();
    chk("rel_outB", 32'(a_out_data), 32'hB);
    chk("rel_occ",  32'(a_occupancy), 32'd1);
    tick();
    chk("rel_outC", 32'(a_out_data), 32'hC);
    a_in_valid = 1'b0;
    tick();
    chk("rel_empty", 32'(a_occupancy), 32'd0);
    chk("rel_stall", 32'(a_stall_cnt), 32'd2);

    // flush with a simultaneous push on A
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h0011;
    tick();
    a_in_data = 16'h0022;
    tick();
    chk("fl_pre_occ", 32'(a_occupancy), 32'd2);
    a_in_flush = 1'b1; a_in_data = 16'h0055;
    tick();
    a_in_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("fl_occ",    32'(a_occupancy), 32'd0);
    chk("fl_bubble", 32'(a_out_data), 32'hBEEF);
    chk("fl_stall",  32'(a_stall_cnt), 32'd3);
    chk("fl_irdy",   32'(a_in_ready), 32'd1);
    tick();
    chk("fl_no55", 32'(a_out_valid), 32'd0);

    // wrap-around on B: 10 pushes, out_ready low every third cycle
    wr_idx = 0;
    rd_idx = 0;
    for (int cyc = 0; cyc < 200 && rd_idx < 10; cyc++) begin
      tick();
      b_out_ready = ((cyc % 3) != 2);
      if (b_out_valid && b_out_ready) begin
        chk("wrap_order", 32'(b_out_data), 32'h100 + 32'(rd_idx));
        rd_idx++;
      end
      b_in_valid = (wr_idx < 10);
      b_in_data  = 16'(16'h100 + wr_idx);
      if (b_in_valid && b_in_ready) wr_idx++;
    end
    b_in_valid = 1'b0;
    chk("wrap_count", 32'(rd_idx), 32'd10);

    // saturation: fill B then stall 20+ cycles
    tick();
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_data = 16'(16'h200 + i);
      tick();
    end
    b_in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", 32'(b_stall_cnt), 32'hF);
    chk("sat_occ",   32'(b_occupancy), 32'd3);
    chk("sat_irdy",  32'(b_in_ready), 32'd0);
    chk("sat_head",  32'(b_out_data), 32'h200);

    // reset while full, with push/pop requests active
    rst_n = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    rst_n = 1'b1; b_in_valid = 1'b0;
    chk("mrst_occ",   32'(b_occupancy), 32'd0);
    chk("mrst_oval",  32'(b_out_valid), 32'd0);
    chk("mrst_odata", 32'(b_out_data), 32'h0);
    chk("mrst_bub",   32'(b_out_is_bubble), 32'd1);
    chk("mrst_irdy",  32'(b_in_ready), 32'd1);
    chk("mrst_stall", 32'(b_stall_cnt), 32'd0);

    // DEPTH=1 on C: one payload per two cycles
    c_out_ready = 1'b1;
    c_in_valid = 1'b1; c_in_data = 16'h00C0;
    tick();
    chk("d1_irdy0", 32'(c_in_ready), 32'd0);
    chk("d1_out0",  32'(c_out_data), 32'hC0);
    c_in_data = 16'h00C1;
    tick();
    chk("d1_occ",   32'(c_occupancy), 32'd0);
    chk("d1_irdy1", 32'(c_in_ready), 32'd1);
    tick();
    chk("d1_out1",  32'(c_out_data), 32'hC1);
    c_in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
# pipeline_stage_buffer

Parametrised inter-stage pipeline buffer for the RealCPU pipeline, the generalised successor of the fixed IF/ID register. It carries an arbitrary-width stage payload (instruction, PC, control bits) through a DEPTH-entry in-order queue with valid/ready handshaking on both sides. It supports flush (bubble insertion on branch/exception) and keeps a saturating stall-cycle counter. One instance sits between each pair of pipeline stages.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc, ins}).
- DEPTH, 2, number of queue entries; legal range 1..16, need not be a power of two.
- BUBBLE, {DATA_W{1'b0}}, value driven on out_data when no entry is valid (NOP encoding).
- CNT_W, 16, width of the stall counter.

Ports:
- sys_clk  in  1  clock; all state updates on the falling edge, as for every pipeline register in the core.
- rst_n  in  1  synchronous active-low reset, sampled on the same falling edge.
- in_valid  in  1  upstream stage presents a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  buffer can accept a payload this cycle.
- in_flush  in  1  discard all stored entries and any same-cycle input.
- out_valid  out  1  head entry is valid.
- out_data  out  DATA_W  head entry payload, or BUBBLE when empty.
- out_ready  in  1  downstream stage consumes the head this cycle (deasserted = downstream stall).
- out_is_bubble  out  1  equals !out_valid, for decoder/hazard logic.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: DEPTH-entry array, read pointer rd_ptr, write pointer wr_ptr, count. Pointers wrap explicitly from DEPTH-1 to 0.
- push = in_valid & in_ready & !in_flush; pop = out_valid & out_ready & !in_flush.
- in_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from out_ready, so the stage boundary is fully registered.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else BUBBLE.
- Count update: push only gives +1; pop only gives −1; push and pop together leave count unchanged and advance both pointers.
- Full (count==DEPTH): in_ready=0. A presented input is not accepted, and the upstream stage must hold in_data/in_valid.
- Empty: out_valid=0 and out_data=BUBBLE. A push becomes visible at the output only after the next edge; there is no bypass.
- Flush: at the edge, count←0 and rd_ptr←wr_ptr←0. The same-cycle input is dropped, and no pop is counted. Flush has priority over push/pop. Memory contents are not cleared.
- stall_cnt: increments by 1 per edge where out_valid & !out_ready & !in_flush. It saturates at all-ones, and only reset clears it.
- Reset (rst_n=0 at a falling edge): count=0, pointers=0, stall_cnt=0. This gives in_ready=1, out_valid=0, out_data=BUBBLE, out_is_bubble=1, occupancy=0. Reset overrides flush, push and pop, including mid-operation with a full queue. Memory is not reset.
- DEPTH=1: the block degenerates to a registered stage with handshake. A push and a pop cannot coincide when full, because in_ready=0.

## Timing
- Latency: a payload accepted at edge N is presented on out_data after edge N, giving 1 cycle minimum latency.
- Throughput: 1 payload/cycle sustained when out_ready=1 and DEPTH≥2. DEPTH=1 sustains 1 per 2 cycles.
- Handshake: a transfer occurs only on an edge where valid & ready are both high. Held data must stay stable while valid=1 and ready=0.
- All outputs are combinational from registers only (no input-to-output paths), except out_is_bubble/out_data, which derive from registered count.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in_valid=1 and in_data=0xDEAD → occupancy=0, out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0.
- Streaming: DEPTH=2, out_ready=1, push 0x1,0x2,0x3 on consecutive edges → out_data shows 0x1,0x2,0x3 on the following edges, occupancy stays 1, stall_cnt=0.
- Fill/stall: out_ready=0, push 0xA,0xB,0xC → after 2 edges in_ready=0, 0xC is held upstream, stall_cnt increments each cycle. Release out_ready → outputs 0xA,0xB,0xC in order.
- Flush with simultaneous push: queue holds 2 entries, assert in_flush with in_valid=1 and data 0x55 → next cycle occupancy=0, out_data=BUBBLE, and 0x55 is never output.
- Wrap-around: DEPTH=3, run 10 pushes with intermittent out_ready → output order equals input order across pointer wrap.
- Saturation and mid-operation reset: CNT_W=4, stall for 20 cycles → stall_cnt=15. Then reset while full → all outputs return to reset values on the next edge.
